// File: rtl/qarma_ctr_engine.sv
// Counter-mode sequencer for the Qarma64 core with a first-word-fall-through keystream FIFO.
// Define QARMA_CTR_TIMEOUT_EN to add a RUN watchdog that drives the sticky error_o flag.
module qarma_ctr_engine #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [63:0] ctr_init_i,
    input  logic [63:0] tweak_i,
    input  logic [15:0] nblocks_i,
    output logic        core_nrst_o,
    output logic [63:0] core_in_o,
    output logic [63:0] core_tweak_o,
    input  logic [63:0] core_out_i,
    input  logic        core_rdy_i,
    output logic [63:0] ks_data_o,
    output logic        ks_valid_o,
    input  logic        ks_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] remaining_o,
    output logic        error_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("qarma_ctr_engine: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, CHECK, LOAD, RUN} state_t;

    state_t        state, state_next;
    logic [63:0]   ctr, tweak;
    logic [15:0]   remaining;
    logic          done;
    logic          accept, push, pop, timeout;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    assign accept = (state == IDLE) && start_i && !abort_i;
    assign pop    = (count != '0) && ks_ready_i && !abort_i;
    assign push   = (state == RUN) && core_rdy_i && !abort_i && ((count != DEPTH_L) || pop);

    always_comb begin
        state_next = state;
        if (abort_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i && nblocks_i != '0) state_next = CHECK;
                CHECK: begin
                    if (remaining == '0)        state_next = IDLE;
                    else if (count < DEPTH_L)   state_next = LOAD;
                end
                LOAD:    state_next = RUN;
                RUN: begin
                    if (core_rdy_i)             state_next = CHECK;
                    else if (timeout)           state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            ctr          <= '0;
            tweak        <= '0;
            remaining    <= '0;
            done         <= 1'b0;
            core_in_o    <= '0;
            core_tweak_o <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (abort_i) begin
                remaining <= '0;
            end else begin
                if (accept) begin
                    ctr       <= ctr_init_i;
                    tweak     <= tweak_i;
                    remaining <= nblocks_i;
                    done      <= (nblocks_i == '0);
                end
                if (state == CHECK && remaining == '0) done <= 1'b1;
                // Core inputs are captured on entry to LOAD and stay frozen through RUN.
                if (state_next == LOAD) begin
                    core_in_o    <= ctr;
                    core_tweak_o <= tweak;
                end
                if (push) begin
                    ctr       <= ctr + 64'd1;
                    remaining <= remaining - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= core_out_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (abort_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef QARMA_CTR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] run_cycles;
    logic          error;

    assign timeout = (state == RUN) && !core_rdy_i && (run_cycles == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            run_cycles <= '0;
            error      <= 1'b0;
        end else begin
            if (state == LOAD)      run_cycles <= '0;
            else if (state == RUN)  run_cycles <= run_cycles + TW'(1);
            if (accept)                     error <= 1'b0;
            else if (timeout && !abort_i)   error <= 1'b1;
        end
    end

    assign error_o = error;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    assign core_nrst_o = (state == RUN);
    assign ks_valid_o  = (count != '0);
    assign ks_data_o   = ks_valid_o ? mem[rd_ptr] : '0;
    assign busy_o      = (state != IDLE);
    assign done_o      = done;
    assign remaining_o = remaining;
endmodule

// File: tb/tb_qarma_ctr_engine.sv
// Directed bench for qarma_ctr_engine: behavioural Qarma64 stand-in plus keystream/core-input scoreboards.
module tb_qarma_ctr_engine;
    logic        clk = 1'b0;
    logic        wb_rst_i, start_i, abort_i, ks_ready_i, core_rdy_i;
    logic [63:0] ctr_init_i, tweak_i, core_out_i;
    logic [15:0] nblocks_i;
    logic        core_nrst_o, ks_valid_o, busy_o, done_o, error_o;
    logic [63:0] core_in_o, core_tweak_o, ks_data_o;
    logic [15:0] remaining_o;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          rises = 0;
    int          run_cnt = 0;
    int          core_lat = 3;
    bit          core_en = 1'b1;
    bit          prev_nrst = 1'b0;
    logic [63:0] exp_ks_q[$];
    logic [63:0] exp_in_q[$];
    logic [63:0] exp_tweak = '0;
    int          d0, r0;

    qarma_ctr_engine #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
        .ctr_init_i(ctr_init_i), .tweak_i(tweak_i), .nblocks_i(nblocks_i),
        .core_nrst_o(core_nrst_o), .core_in_o(core_in_o), .core_tweak_o(core_tweak_o),
        .core_out_i(core_out_i), .core_rdy_i(core_rdy_i),
        .ks_data_o(ks_data_o), .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i),
        .busy_o(busy_o), .done_o(done_o), .remaining_o(remaining_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] core_f(input logic [63:0] p, input logic [63:0] t);
        return {p[31:0], p[63:32]} ^ t ^ 64'h5A5A_0F0F_C3C3_9669;
    endfunction

    // Stand-in core: rdy pulses in the core_lat-th cycle of nrst high.
    initial begin
        core_rdy_i = 1'b0;
        core_out_i = '0;
        forever begin
            @(posedge clk);
            #1;
            core_rdy_i = 1'b0;
            if (!core_nrst_o) begin
                run_cnt = 0;
            end else begin
                run_cnt++;
                if (core_en && run_cnt == core_lat) begin
                    core_rdy_i = 1'b1;
                    core_out_i = core_f(core_in_o, core_tweak_o);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [63:0] e;
        if (ks_valid_o && ks_ready_i && !abort_i && !wb_rst_i) begin
            checks++;
            assert (exp_ks_q.size() != 0)
            else begin
                errors++;
                $error("FAIL ks_unexpected: observed word %h expected none", ks_data_o);
            end
            if (exp_ks_q.size() != 0) begin
                e = exp_ks_q.pop_front();
                check("ks_data", ks_data_o, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (done_o) done_cnt++;
        if (core_nrst_o && !prev_nrst) begin
            rises++;
            checks++;
            assert (exp_in_q.size() != 0)
            else begin
                errors++;
                $error("FAIL core_start_unexpected: observed core_in %h expected no block", core_in_o);
            end
            if (exp_in_q.size() != 0) begin
                e = exp_in_q.pop_front();
                check("core_in", core_in_o, e);
                check("core_tweak", core_tweak_o, exp_tweak);
            end
        end
        prev_nrst = core_nrst_o;
    endtask

    task automatic start_run(input logic [63:0] c, input logic [63:0] t, input int unsigned n,
                             input bit with_ks);
        logic [63:0] v;
        ctr_init_i = c;
        tweak_i    = t;
        nblocks_i  = 16'(n);
        start_i    = 1'b1;
        exp_tweak  = t;
        for (int unsigned i = 0; i < n; i++) begin
            v = c + 64'(i);
            exp_in_q.push_back(v);
            if (with_ks) exp_ks_q.push_back(core_f(v, t));
        end
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (ks_valid_o && n < budget) begin
            tick();
            n++;
        end
        check("drain_valid", 64'(ks_valid_o), 64'd0);
    endtask

    task automatic wait_rdy(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!core_rdy_i && n < budget) begin
            tick();
            n++;
        end
        check("wait_rdy", 64'(core_rdy_i), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ks_ready_i = 1'b0;
        ctr_init_i = '0; tweak_i = '0; nblocks_i = '0;
        repeat (2) @(negedge clk);
        check("rst_core_nrst", 64'(core_nrst_o), 64'd0);
        check("rst_core_in", core_in_o, 64'd0);
        check("rst_core_tweak", core_tweak_o, 64'd0);
        check("rst_ks_valid", 64'(ks_valid_o), 64'd0);
        check("rst_ks_data", ks_data_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_remaining", 64'(remaining_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        wb_rst_i = 1'b0;
        tick();

        // Single block, 10-cycle core
        core_lat = 10; ks_ready_i = 1'b1; d0 = done_cnt;
        start_run(64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0BAD_F00D, 1, 1'b1);
        check("t1_busy", 64'(busy_o), 64'd1);
        check("t1_check_nrst", 64'(core_nrst_o), 64'd0);
        check("t1_remaining_1", 64'(remaining_o), 64'd1);
        tick();
        check("t1_load_core_in", core_in_o, 64'h0123_4567_89AB_CDEF);
        check("t1_load_nrst", 64'(core_nrst_o), 64'd0);
        tick();
        check("t1_run_nrst", 64'(core_nrst_o), 64'd1);
        wait_rdy(30);
        tick();
        check("t1_valid_after_rdy", 64'(ks_valid_o), 64'd1);
        check("t1_remaining_0", 64'(remaining_o), 64'd0);
        wait_idle(20); drain(20); repeat (2) tick();
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_ks_left", 64'(exp_ks_q.size()), 64'd0);

        // Backpressure: 6 blocks into a 4-deep FIFO
        core_lat = 3; ks_ready_i = 1'b0; d0 = done_cnt; r0 = rises;
        start_run(64'h0000_0000_0000_1000, 64'h7777_0000_1111_2222, 6, 1'b1);
        repeat (60) tick();
        check("bp_blocks_started", 64'(rises - r0), 64'd4);
        check("bp_remaining", 64'(remaining_o), 64'd2);
        check("bp_nrst_parked", 64'(core_nrst_o), 64'd0);
        check("bp_busy", 64'(busy_o), 64'd1);
        check("bp_valid", 64'(ks_valid_o), 64'd1);
        repeat (20) tick();
        check("bp_still_parked", 64'(rises - r0), 64'd4);
        ks_ready_i = 1'b1;
        wait_idle(100); drain(20); repeat (2) tick();
        check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("bp_ks_left", 64'(exp_ks_q.size()), 64'd0);
        check("bp_in_left", 64'(exp_in_q.size()), 64'd0);

        // Counter wrap
        d0 = done_cnt; r0 = rises;
        start_run(64'hFFFF_FFFF_FFFF_FFFE, 64'h0F0F_F0F0_3333_CCCC, 3, 1'b1);
        wait_idle(100); drain(20); repeat (2) tick();
        check("wrap_blocks", 64'(rises - r0), 64'd3);
        check("wrap_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("wrap_ks_left", 64'(exp_ks_q.size()), 64'd0);

        // Abort during block 2 RUN with rdy high
        core_lat = 4; ks_ready_i = 1'b0; d0 = done_cnt; r0 = rises;
        start_run(64'h0000_0000_0000_2000, 64'h0000_0000_0000_ABCD, 5, 1'b1);
        for (int unsigned n = 0; n < 50 && !(core_rdy_i && rises - r0 == 2); n++) tick();
        check("ab_rdy_block2", 64'(core_rdy_i && (rises - r0 == 2)), 64'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("ab_busy", 64'(busy_o), 64'd0);
        check("ab_valid", 64'(ks_valid_o), 64'd0);
        check("ab_remaining", 64'(remaining_o), 64'd0);
        check("ab_nrst", 64'(core_nrst_o), 64'd0);
        repeat (5) tick();
        check("ab_no_done", 64'(done_cnt - d0), 64'd0);
        check("ab_stays_idle", 64'(busy_o), 64'd0);
        exp_ks_q.delete(); exp_in_q.delete();

        // Zero-length run
        d0 = done_cnt;
        start_run(64'h0000_0000_0000_3000, 64'h1, 0, 1'b1);
        check("z_done_next", 64'(done_o), 64'd1);
        check("z_busy", 64'(busy_o), 64'd0);
        check("z_nrst", 64'(core_nrst_o), 64'd0);
        tick();
        check("z_done_one_cycle", 64'(done_o), 64'd0);
        check("z_nrst_after", 64'(core_nrst_o), 64'd0);
        check("z_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Start while busy is ignored
        core_lat = 5; ks_ready_i = 1'b1; d0 = done_cnt; r0 = rises;
        start_run(64'hAAAA_0000_0000_0010, 64'h0123_0000_FFFF_0000, 2, 1'b1);
        repeat (3) tick();
        ctr_init_i = 64'h5555_5555_5555_5555; tweak_i = 64'h9999_9999_9999_9999;
        nblocks_i = 16'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("ign_remaining", 64'(remaining_o), 64'd2);
        wait_idle(100); drain(20); repeat (2) tick();
        check("ign_blocks", 64'(rises - r0), 64'd2);
        check("ign_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("ign_ks_left", 64'(exp_ks_q.size()), 64'd0);

`ifdef QARMA_CTR_TIMEOUT_EN
        // Timeout with a core that never answers
        core_en = 1'b0; d0 = done_cnt;
        start_run(64'h42, 64'h99, 1, 1'b0);
        tick(); tick();
        check("to_run_nrst", 64'(core_nrst_o), 64'd1);
        repeat (15) tick();
        check("to_error_before", 64'(error_o), 64'd0);
        check("to_busy_before", 64'(busy_o), 64'd1);
        tick();
        check("to_error_set", 64'(error_o), 64'd1);
        check("to_idle", 64'(busy_o), 64'd0);
        check("to_nrst", 64'(core_nrst_o), 64'd0);
        repeat (3) tick();
        check("to_error_sticky", 64'(error_o), 64'd1);
        check("to_no_done", 64'(done_cnt - d0), 64'd0);
        core_en = 1'b1; d0 = done_cnt;
        start_run(64'h43, 64'h99, 1, 1'b1);
        check("to_error_cleared", 64'(error_o), 64'd0);
        wait_idle(100); drain(20); repeat (2) tick();
        check("to_rerun_done", 64'(done_cnt - d0), 64'd1);
`else
        // Without the watchdog RUN waits until aborted
        core_en = 1'b0;
        start_run(64'h42, 64'h99, 1, 1'b0);
        repeat (40) tick();
        check("nto_error", 64'(error_o), 64'd0);
        check("nto_busy", 64'(busy_o), 64'd1);
        check("nto_nrst", 64'(core_nrst_o), 64'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("nto_abort_idle", 64'(busy_o), 64'd0);
        check("nto_abort_nrst", 64'(core_nrst_o), 64'd0);
        core_en = 1'b1;
        exp_in_q.delete();
`endif

        // Reset in the middle of a run
        ks_ready_i = 1'b0; core_lat = 6; d0 = done_cnt;
        start_run(64'h0000_0000_0000_5555, 64'h1, 3, 1'b1);
        repeat (4) tick();
        check("mr_run_nrst", 64'(core_nrst_o), 64'd1);
        wb_rst_i = 1'b1;
        #1;
        check("mr_busy", 64'(busy_o), 64'd0);
        check("mr_nrst", 64'(core_nrst_o), 64'd0);
        check("mr_core_in", core_in_o, 64'd0);
        check("mr_remaining", 64'(remaining_o), 64'd0);
        check("mr_valid", 64'(ks_valid_o), 64'd0);
        check("mr_error", 64'(error_o), 64'd0);
        tick(); tick();
        wb_rst_i = 1'b0;
        repeat (3) tick();
        check("mr_no_done", 64'(done_cnt - d0), 64'd0);
        check("mr_idle", 64'(busy_o), 64'd0);
        exp_ks_q.delete(); exp_in_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
